// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame sequencer: sequencer states,
// default frame timing and a small width helper.
package audio_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_t;

    localparam int DEF_CLK_PER_SAMPLE = 833;
    localparam int DEF_XFER_CLKS      = 512;
    localparam int DEF_ADC_DIV_LOG2   = 3;
    localparam int DEF_PI_DIV_LOG2    = 5;
    localparam int DEF_NUM_CH         = 2;
    localparam int DEF_ADDR_W         = 13;

    // A channel index always occupies at least one bit, even with one channel.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// RAM-side bus of the frame sequencer: read/write slot strobes, channel and address.
interface frame_sequencer_if
    import audio_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int CH_W  = ch_bits(NUM_CH)
);

    logic              rd_strobe;
    logic              we;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;

    modport master (output rd_strobe, output we, output ch, output addr);
    modport slave  (input  rd_strobe, input  we, input  ch, input  addr);

endinterface

// File: rtl/delay_addr_gen.sv
// Delay-line pointer keeper: owns the write pointer and the latched delay,
// and produces the registered RAM address/channel for each read or write slot.
module delay_addr_gen
    import audio_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ADDR_W  = DEF_ADDR_W,
    localparam int CH_W   = ch_bits(NUM_CH),
    localparam int PTR_W  = ADDR_W - $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              latch_delay,
    input  logic [PTR_W-1:0]  delay,
    input  logic              rd_slot,
    input  logic              wr_slot,
    input  logic [CH_W-1:0]   slot_ch,
    output logic [ADDR_W-1:0] addr,
    output logic [CH_W-1:0]   ch
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  delay_l_q, delay_l_d;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  slot_ptr;
    logic [ADDR_W-1:0] slot_addr;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    // The channel selects the RAM bank above the pointer; a single channel uses the pointer alone.
    if (NUM_CH > 1) begin : g_multi_ch
        assign slot_addr = {slot_ch, slot_ptr};
    end else begin : g_single_ch
        assign slot_addr = slot_ptr;
    end

    // Next pointer/delay and the address of the upcoming slot; the delay port is
    // PTR_W wide, so it can never exceed DEPTH-1 and needs no further clamping.
    always_comb begin
        wr_ptr_d  = advance ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        delay_l_d = latch_delay ? delay : delay_l_q;
        rd_ptr    = wr_ptr_d - delay_l_d;
        slot_ptr  = rd_slot ? rd_ptr : wr_ptr_d;
        addr_d    = addr_q;
        ch_d      = ch_q;
        if (rd_slot || wr_slot) begin
            addr_d = slot_addr;
            ch_d   = slot_ch;
        end
    end

    // Pointer, latched delay and held address/channel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            delay_l_q <= '0;
            addr_q    <= '0;
            ch_q      <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            delay_l_q <= delay_l_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
        end
    end

    assign addr = addr_q;
    assign ch   = ch_q;

endmodule

// File: rtl/frame_sequencer.sv
// Audio frame sequencer: frame counter, run/drain FSM, serial clocks, transfer
// window and the per-channel RAM read/write slots of a delay line.
module frame_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = DEF_CLK_PER_SAMPLE,
    parameter int XFER_CLKS      = DEF_XFER_CLKS,
    parameter int ADC_DIV_LOG2   = DEF_ADC_DIV_LOG2,
    parameter int PI_DIV_LOG2    = DEF_PI_DIV_LOG2,
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int ADDR_W         = DEF_ADDR_W,
    localparam int CH_W          = ch_bits(NUM_CH),
    localparam int PTR_W         = ADDR_W - $clog2(NUM_CH),
    localparam int CNT_W         = $clog2(CLK_PER_SAMPLE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PTR_W-1:0] delay,
    output logic             sclk_adc,
    output logic             sclk_pi,
    output logic             xfer_en,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             busy,
    frame_sequencer_if.master ram
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_SAMPLE - 1);
    localparam logic [CNT_W-1:0] RD_BASE  = CNT_W'(XFER_CLKS);
    localparam logic [CNT_W-1:0] RD_END   = CNT_W'(XFER_CLKS + NUM_CH);
    localparam logic [CNT_W-1:0] WR_BASE  = CNT_W'(CLK_PER_SAMPLE - NUM_CH);

    // Frame timing must leave room for the read and write slots after the
    // transfer window, and the window must hold whole Pi clock periods.
    if (CLK_PER_SAMPLE <= XFER_CLKS + 2 * NUM_CH) begin : g_bad_frame_len
        $error("frame_sequencer: CLK_PER_SAMPLE must exceed XFER_CLKS + 2*NUM_CH");
    end
    if ((XFER_CLKS % (2 ** (PI_DIV_LOG2 + 1))) != 0) begin : g_bad_xfer_len
        $error("frame_sequencer: XFER_CLKS must be a multiple of 2^(PI_DIV_LOG2+1)");
    end
    if (NUM_CH < 1 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
        $error("frame_sequencer: NUM_CH must be a power of two");
    end

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             busy_q, busy_d;
    logic             sclk_adc_q, sclk_adc_d;
    logic             sclk_pi_q, sclk_pi_d;
    logic             xfer_en_q, xfer_en_d;
    logic             frame_start_q, frame_start_d;
    logic             rd_strobe_q, rd_strobe_d;
    logic             we_q, we_d;
    logic             active;
    logic             frame_end;
    logic             latch_delay;
    logic [CH_W-1:0]  slot_ch;
    logic [ADDR_W-1:0] gen_addr;
    logic [CH_W-1:0]  gen_ch;

    // Next state/counter plus every output decoded from that next state, so the
    // outputs leave flops and line up exactly with the state they describe.
    always_comb begin
        active      = (state_q != SEQ_IDLE);
        frame_end   = active && (cnt_q == LAST_CNT);
        latch_delay = active && (cnt_q == '0);
        state_d     = state_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            SEQ_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = SEQ_RUN;
            end
            SEQ_RUN: begin
                cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
                if (!enable) state_d = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                if (enable) begin
                    state_d = SEQ_RUN;
                    cnt_d   = frame_end ? '0 : cnt_q + CNT_W'(1);
                end else if (frame_end) begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d        = (state_d != SEQ_IDLE);
        sclk_adc_d    = busy_d && cnt_d[ADC_DIV_LOG2];
        sclk_pi_d     = busy_d && cnt_d[PI_DIV_LOG2];
        xfer_en_d     = (state_d == SEQ_RUN) && (cnt_d < RD_BASE);
        frame_start_d = (state_d == SEQ_RUN) && (cnt_d == '0);
        rd_strobe_d   = busy_d && (cnt_d >= RD_BASE) && (cnt_d < RD_END);
        we_d          = busy_d && (cnt_d >= WR_BASE);
        slot_ch       = rd_strobe_d ? CH_W'(cnt_d - RD_BASE) : CH_W'(cnt_d - WR_BASE);
        frame_cnt_d   = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Sequencer state, frame counter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SEQ_IDLE;
            cnt_q         <= '0;
            frame_cnt_q   <= '0;
            busy_q        <= 1'b0;
            sclk_adc_q    <= 1'b0;
            sclk_pi_q     <= 1'b0;
            xfer_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            rd_strobe_q   <= 1'b0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            busy_q        <= busy_d;
            sclk_adc_q    <= sclk_adc_d;
            sclk_pi_q     <= sclk_pi_d;
            xfer_en_q     <= xfer_en_d;
            frame_start_q <= frame_start_d;
            rd_strobe_q   <= rd_strobe_d;
            we_q          <= we_d;
        end
    end

    delay_addr_gen #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .advance     (frame_end),
        .latch_delay (latch_delay),
        .delay       (delay),
        .rd_slot     (rd_strobe_d),
        .wr_slot     (we_d),
        .slot_ch     (slot_ch),
        .addr        (gen_addr),
        .ch          (gen_ch)
    );

    assign sclk_adc      = sclk_adc_q;
    assign sclk_pi       = sclk_pi_q;
    assign xfer_en       = xfer_en_q;
    assign frame_start   = frame_start_q;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = busy_q;
    assign ram.rd_strobe = rd_strobe_q;
    assign ram.we        = we_q;
    assign ram.addr      = gen_addr;
    assign ram.ch        = gen_ch;

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_PER_SAMPLE, 833, clk cycles per sample frame.
- XFER_CLKS, 512, cycles at frame start during which converter/Pi transfers are enabled.
- ADC_DIV_LOG2, 3, ADC sclk equals frame counter bit [ADC_DIV_LOG2].
- PI_DIV_LOG2, 5, Pi sclk equals frame counter bit [PI_DIV_LOG2].
- NUM_CH, 2, time-multiplexed audio channels; power of two, at least 1.
- ADDR_W, 13, RAM address width; PTR_W = ADDR_W - clog2(NUM_CH), DEPTH = 2^PTR_W.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  run request.
- delay  in  PTR_W  delay-line length in frames.
- sclk_adc  out  1  ADC serial clock.
- sclk_pi  out  1  Pi serial clock.
- xfer_en  out  1  transfer window, high while frame counter < XFER_CLKS in RUN.
- frame_start  out  1  one-cycle pulse when frame counter = 0 in RUN.
- rd_strobe  out  1  read slot active; RAM data is valid next cycle.
- we  out  1  RAM write enable.
- ch  out  clog2(NUM_CH) max 1  channel of the current read or write slot.
- addr  out  ADDR_W  RAM address = {ch, pointer}.
- frame_cnt  out  16  completed frames, wraps.
- busy  out  1  high in RUN or DRAIN.

Function
REQ-003 FSM states: IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->RUN when enable=1 before frame end; DRAIN->IDLE at frame end.
REQ-004 Frame counter counts 0..CLK_PER_SAMPLE-1 in RUN/DRAIN, wraps to 0, and is held at 0 in IDLE.
REQ-005 sclk_adc and sclk_pi are counter bits gated by busy, and are 0 in IDLE.
REQ-006 xfer_en and frame_start are asserted only in RUN; DRAIN never begins a new transfer.
REQ-007 delay is latched at counter=0 only and clamped to DEPTH-1; mid-frame changes take effect at the next frame.
REQ-008 Read slot for channel c is at counter XFER_CLKS+c: rd_strobe=1, ch=c, addr={c, wr_ptr - delay_l mod DEPTH}.
REQ-009 Write slot for channel c is at counter CLK_PER_SAMPLE-NUM_CH+c: we=1, ch=c, addr={c, wr_ptr}.
REQ-010 Outside slots, rd_strobe=0, we=0, and addr/ch hold their last value.
REQ-011 wr_ptr increments modulo DEPTH on the cycle after the last write slot (frame end), and frame_cnt increments on the same cycle.
REQ-012 delay=0 makes the read address equal to the current write address, so the read returns the sample written DEPTH frames earlier.
REQ-013 Write slots complete in DRAIN; a frame is never truncated by enable=0.
REQ-014 Static checks: CLK_PER_SAMPLE > XFER_CLKS+2*NUM_CH; 2^(PI_DIV_LOG2+1) divides XFER_CLKS; violation is an elaboration error.

Reset
REQ-015 Asynchronous reset forces IDLE, counter=0, wr_ptr=0, delay_l=0, frame_cnt=0, addr=0, ch=0, and all 1-bit outputs to 0.
REQ-016 Reset mid-frame aborts the frame with no we pulse; the next frame after release starts at counter=0.

Structure
REQ-017 The state enum and default timing constants SHALL reside in shared package audio_pkg.
REQ-018 The delay-line pointer and address arithmetic SHALL be one sub-module, delay_addr_gen; counter, FSM and strobes remain in frame_sequencer.

Verification
REQ-019 Defaults, enable=1 from reset release: frame_start at cycles 0 and 833; xfer_en high for cycles 0-511; sclk_adc period 16 clk; sclk_pi period 64 clk.
REQ-020 delay=5, run 10 frames: in frame 10 the ch0 read addr = {0,5}, and we writes {0,10} at counter 831 and {1,10} at counter 832.
REQ-021 wr_ptr=4095, delay=3: frame wraps ptr to 0; the next read addr = {c,4093}.
REQ-022 delay=4095 applied at counter 600: the current frame still uses the old delay; the next frame reads {c, wr_ptr+1}.
REQ-023 enable dropped at counter 100: DRAIN finishes the frame with both we pulses, then IDLE; no frame_start follows, and busy=0 after counter 832.
REQ-024 reset asserted at counter 700: all outputs are 0 immediately, no we pulse occurs, and frame_cnt=0.
